// File: rtl/shift_register_with_valid_ready_if.sv
// Handshake bundle for shift_register_with_valid_ready: upstream and downstream valid/ready,
// plus flush and the occupancy count.
interface shift_register_with_valid_ready_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] in_data;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data, count
  );

  modport slave (
    input  flush, in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data, count
  );
endinterface

// File: rtl/shift_register_with_valid_ready.sv
// Elastic DEPTH-stage delay line with valid/ready on both sides, bubble collapsing,
// occupancy count and synchronous flush. Optional macro SHIFT_REG_VR_X_BUBBLE_EN loads 'x into bubbles.
module shift_register_with_valid_ready #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  shift_register_with_valid_ready_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_acc;
  logic             w_in_hs;
  logic             w_out_hs;

  // A stage can take new data if it is empty or its occupant moves on; a scalar
  // carries the chain downward so the vector never feeds back on itself.
  always_comb begin
    logic w_chain;
    w_acc   = '0;
    w_chain = !r_vld[DEPTH-1] || bus.out_rdy;
    w_acc[DEPTH-1] = w_chain;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_chain  = !r_vld[i] || w_chain;
      w_acc[i] = w_chain;
    end
  end

  assign bus.in_rdy   = w_acc[0] && !bus.flush;
  assign bus.out_vld  = r_vld[DEPTH-1];
  assign bus.out_data = r_data[DEPTH-1];
  assign bus.count    = r_count;

  assign w_in_hs  = bus.in_vld && bus.in_rdy;
  assign w_out_hs = r_vld[DEPTH-1] && bus.out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else if (bus.flush) begin
      r_vld   <= '0;
      r_count <= '0;
    end else begin
      if (w_acc[0]) begin
        r_vld[0] <= bus.in_vld;
        if (bus.in_vld) r_data[0] <= bus.in_data;
`ifdef SHIFT_REG_VR_X_BUBBLE_EN
        else r_data[0] <= 'x;
`endif
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_acc[i]) begin
          r_vld[i] <= r_vld[i-1];
          if (r_vld[i-1]) r_data[i] <= r_data[i-1];
`ifdef SHIFT_REG_VR_X_BUBBLE_EN
          else r_data[i] <= 'x;
`endif
        end
      end
      // Count tracks handshakes rather than popcount so it stays a plain register.
      r_count <= r_count + CW'(w_in_hs) - CW'(w_out_hs);
    end
  end
endmodule

// File: tb/tb_shift_register_with_valid_ready.sv
// Self-checking bench for shift_register_with_valid_ready (WIDTH=8, DEPTH=4): hand tables,
// directed corner sequences and random traffic against a transfer-position reference model.
module tb_shift_register_with_valid_ready;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  shift_register_with_valid_ready_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  shift_register_with_valid_ready #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nAssert = 0;
  int nFail   = 0;

  // Reference: each held transfer with its stage position, oldest first.
  logic [WIDTH-1:0] mData [$];
  int               mPos  [$];

  typedef struct {
    bit               inVld;
    logic [WIDTH-1:0] inData;
    bit               outRdy;
    bit               expInRdy;
    bit               expOutVld;
    logic [WIDTH-1:0] expData;
    int               expCount;
  } vec_t;

  vec_t tbl [11];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nAssert++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit fl, input bit iv, input logic [WIDTH-1:0] d,
                               input bit ordy);
    rst         = r;
    bus.flush   = fl;
    bus.in_vld  = iv;
    bus.in_data = d;
    bus.out_rdy = ordy;
    #1;
  endtask

  function automatic bit modelInRdy();
    return (mPos.size() < DEPTH || bus.out_rdy) && !bus.flush;
  endfunction

  function automatic bit modelOutVld();
    return mPos.size() > 0 && mPos[0] == DEPTH - 1;
  endfunction

  // Transfers move toward the output whenever the slot ahead is free or vacates this edge.
  task automatic modelAdvance();
    bit inHs;
    int n;
    int p;
    int prevPos;
    bit mv;
    bit prevMove;
    inHs = bus.in_vld && modelInRdy();
    if (rst || bus.flush) begin
      mData.delete();
      mPos.delete();
      return;
    end
    n = mPos.size();
    prevPos = 0;
    prevMove = 1'b0;
    for (int k = 0; k < n; k++) begin
      p = mPos[k];
      if (k == 0) mv = (p < DEPTH - 1) || bus.out_rdy;
      else        mv = (p + 1 < prevPos) || prevMove;
      prevPos  = p;
      prevMove = mv;
      if (mv) mPos[k] = p + 1;
    end
    if (n > 0 && mPos[0] == DEPTH) begin
      void'(mPos.pop_front());
      void'(mData.pop_front());
    end
    if (inHs) begin
      mData.push_back(bus.in_data);
      mPos.push_back(0);
    end
  endtask

  task automatic runCycle(input string tag);
    checkOutput({tag, ".in_rdy"},  32'(bus.in_rdy),  32'(modelInRdy()));
    checkOutput({tag, ".out_vld"}, 32'(bus.out_vld), 32'(modelOutVld()));
    checkOutput({tag, ".count"},   32'(bus.count),   32'(mPos.size()));
    if (modelOutVld()) checkOutput({tag, ".out_data"}, 32'(bus.out_data), 32'(mData[0]));
    @(posedge clk);
    modelAdvance();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, '0, ordy);
      runCycle("idle");
    end
  endtask

  initial begin
    tbl[0]  = '{1, 8'hA0, 0, 1, 0, 8'h00, 0};
    tbl[1]  = '{1, 8'hA1, 0, 1, 0, 8'h00, 1};
    tbl[2]  = '{1, 8'hA2, 0, 1, 0, 8'h00, 2};
    tbl[3]  = '{1, 8'hA3, 0, 1, 0, 8'h00, 3};
    tbl[4]  = '{1, 8'hA4, 0, 0, 1, 8'hA0, 4};
    tbl[5]  = '{1, 8'hA4, 1, 1, 1, 8'hA0, 4};
    tbl[6]  = '{0, 8'h00, 1, 1, 1, 8'hA1, 4};
    tbl[7]  = '{0, 8'h00, 1, 1, 1, 8'hA2, 3};
    tbl[8]  = '{0, 8'h00, 1, 1, 1, 8'hA3, 2};
    tbl[9]  = '{0, 8'h00, 1, 1, 1, 8'hA4, 1};
    tbl[10] = '{0, 8'h00, 1, 1, 0, 8'h00, 0};

    @(negedge clk);
    applyStimulus(1, 0, 0, '0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    mData.delete();
    mPos.delete();

    applyStimulus(0, 0, 0, '0, 0);
    checkOutput("reset.in_rdy",   32'(bus.in_rdy),   32'd1);
    checkOutput("reset.out_vld",  32'(bus.out_vld),  32'd0);
    checkOutput("reset.out_data", 32'(bus.out_data), 32'd0);
    checkOutput("reset.count",    32'(bus.count),    32'd0);

    $display("[TB] stall/fill table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, 0, tbl[i].inVld, tbl[i].inData, tbl[i].outRdy);
      checkOutput($sformatf("tbl%0d.in_rdy", i),  32'(bus.in_rdy),  32'(tbl[i].expInRdy));
      checkOutput($sformatf("tbl%0d.out_vld", i), 32'(bus.out_vld), 32'(tbl[i].expOutVld));
      checkOutput($sformatf("tbl%0d.count", i),   32'(bus.count),   32'(tbl[i].expCount));
      if (tbl[i].expOutVld)
        checkOutput($sformatf("tbl%0d.out_data", i), 32'(bus.out_data), 32'(tbl[i].expData));
      runCycle("tbl");
    end

    $display("[TB] streaming");
    for (int c = 0; c < 13; c++) begin
      applyStimulus(0, 0, c < 8, 8'(c + 1), 1);
      checkOutput("stream.in_rdy",  32'(bus.in_rdy),  32'd1);
      checkOutput("stream.out_vld", 32'(bus.out_vld), 32'(c >= 4 && c < 12));
      checkOutput("stream.count",   32'(bus.count),   32'(c <= 4 ? c : (c <= 8 ? 4 : 12 - c)));
      if (c >= 4 && c < 12) checkOutput("stream.out_data", 32'(bus.out_data), 32'(c - 3));
      runCycle("stream");
    end

    $display("[TB] bubble collapse");
    applyStimulus(0, 0, 1, 8'h11, 0); runCycle("bub");
    idle(2, 0);
    applyStimulus(0, 0, 1, 8'h22, 0); runCycle("bub");
    idle(2, 0);
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("bubble.count",  32'(bus.count),    32'd2);
    checkOutput("bubble.first",  32'(bus.out_data), 32'h11);
    runCycle("bub");
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("bubble.second", 32'(bus.out_data), 32'h22);
    checkOutput("bubble.vld2",   32'(bus.out_vld),  32'd1);
    runCycle("bub");
    idle(3, 1);

    $display("[TB] full simultaneous");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 8'(8'hC0 + i), 0);
      runCycle("full");
    end
    applyStimulus(0, 0, 1, 8'hC4, 1);
    checkOutput("full.in_rdy", 32'(bus.in_rdy), 32'd1);
    runCycle("full");
    applyStimulus(0, 0, 0, '0, 0);
    checkOutput("full.count",    32'(bus.count),    32'd4);
    checkOutput("full.out_data", 32'(bus.out_data), 32'hC1);
    runCycle("full");
    idle(6, 1);

    $display("[TB] flush");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 8'(8'hD0 + i), 0);
      runCycle("flush");
    end
    applyStimulus(0, 1, 1, 8'h55, 0);
    checkOutput("flush.in_rdy", 32'(bus.in_rdy), 32'd0);
    runCycle("flush");
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("flush.out_vld", 32'(bus.out_vld), 32'd0);
    checkOutput("flush.count",   32'(bus.count),   32'd0);
    runCycle("flush");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, '0, 1);
      checkOutput("flush.no55", 32'(bus.out_vld), 32'd0);
      runCycle("flush");
    end

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 8'(8'hE0 + i), 0);
      runCycle("rstm");
    end
    applyStimulus(1, 0, 1, 8'h99, 0);
    runCycle("rstm");
    applyStimulus(0, 0, 0, '0, 0);
    checkOutput("rstm.out_vld",  32'(bus.out_vld),  32'd0);
    checkOutput("rstm.out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rstm.count",    32'(bus.count),    32'd0);
    checkOutput("rstm.in_rdy",   32'(bus.in_rdy),   32'd1);
    runCycle("rstm");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, '0, 1);
      checkOutput("rstm.stale", 32'(bus.out_vld), 32'd0);
      runCycle("rstm");
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 9) < 7,
                    8'($urandom),
                    $urandom_range(0, 9) < 6);
      runCycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule

// File: doc/shift_register_with_valid_ready.md
Name: shift_register_with_valid_ready

Overview:
- Parametrised successor to the valid-only shift register.
- DEPTH-stage pipeline of WIDTH-bit transfers with a valid/ready handshake on both sides.
- Bubble collapsing: when the output stalls, empty stages still fill, so no valid transfer is lost or overwritten.
- Used as an elastic delay line between pipelined arithmetic stages. Also provides an occupancy count and a synchronous flush.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=2).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of all stored transfers.
- in_vld  input  1  upstream transfer valid.
- in_rdy  output  1  block can accept a transfer this cycle.
- in_data  input  WIDTH  upstream data.
- out_vld  output  1  last stage holds a valid transfer.
- out_rdy  input  1  downstream accepts the transfer this cycle.
- out_data  output  WIDTH  last-stage data.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- State: per stage i (0..DEPTH-1), vld[i] and data[i]. Stage DEPTH-1 drives out_vld and out_data directly (registered outputs).
- Accept chain, combinational:
  - acc[DEPTH-1] = !vld[DEPTH-1] || out_rdy.
  - acc[i] = !vld[i] || (vld[i] && acc[i+1]).
  - in_rdy = acc[0] && !flush.
- Transfers:
  - Input handshake: in_vld && in_rdy.
  - Output handshake: out_vld && out_rdy.
- Per-edge update, stage i>0:
  - If acc[i]: vld[i] <= vld[i-1], and data[i] <= data[i-1] when vld[i-1].
  - Else: hold.
- Stage 0:
  - If acc[0]: vld[0] <= in_vld, and data[0] <= in_data when in_vld.
  - Else: hold.
- Bubbles: when the destination stage accepts but the source is empty, the valid bit clears and data holds its previous value (see Optional Feature).
- Latency: a transfer accepted at edge t is presented on out_vld/out_data after edge t+DEPTH-1 when there are no stalls. This is DEPTH cycles from in_vld to visible output.
- Throughput: 1 transfer/cycle when out_rdy is held at 1.
- Ordering: strict FIFO. No duplication and no loss under any out_rdy pattern.
- Full: count==DEPTH and out_rdy=0 -> in_rdy=0. If out_rdy=1 in the same cycle, in_rdy=1 (simultaneous accept and drain, count unchanged).
- Empty: count==0 -> out_vld=0, in_rdy=1 (unless flush).
- count: registered. Next value = count + input handshake − output handshake, before flush is applied. Never exceeds DEPTH.
- Flush:
  - All vld <= 0 and count <= 0 at the next edge.
  - in_rdy=0 during the flush cycle, so no input is accepted.
  - out_vld may still be 1 during the flush cycle. An output handshake that cycle counts as delivered.
  - data is not cleared.
- Reset:
  - Priority rst > flush > normal operation.
  - All vld=0, all data=0, count=0.
  - Resulting outputs: out_vld=0, out_data=0, count=0, and in_rdy=1 once rst deasserts.
  - Reset mid-stream discards all held transfers.
- out_data is don't-care whenever out_vld=0.

Optional Feature:
- Macro SHIFT_REG_VR_X_BUBBLE_EN.
- When defined: a stage that receives a bubble loads 'x into data (simulation aid that exposes consumers sampling invalid data). Reset still loads 0.
- When undefined: a bubble leaves the stage's data unchanged (lower toggle power). Functionally identical on all valid transfers.

Test Plan:
- Test configuration is WIDTH=8, DEPTH=4.
- Streaming: out_rdy=1, in_vld=1 with data 0x01..0x08 on consecutive cycles -> out_vld rises 4 cycles after first accept, then 0x01..0x08 appear back-to-back. in_rdy stays 1, count stays 4 in steady state.
- Stall/fill: out_rdy=0, push 0xA0,0xA1,0xA2,0xA3,0xA4 -> first four accepted, in_rdy=0 on the fifth, count=4, out_data=0xA0. Then raise out_rdy for 5 cycles -> outputs 0xA0..0xA4 in order, and 0xA4 is accepted in the same cycle out_rdy rises.
- Bubble collapse: push 0x11, gap 2 cycles, push 0x22, with out_rdy=0 -> both collapse into stages 3 and 2, count=2. Release out_rdy -> 0x11 then 0x22 on consecutive cycles.
- Full simultaneous: count=4, in_vld=1, out_rdy=1 -> in_rdy=1, one in and one out, count stays 4.
- Flush: count=3, assert flush one cycle with in_vld=1 -> in_rdy=0 that cycle, next cycle out_vld=0, count=0. Input 0x55 is not accepted.
- Reset mid-stream: rst with count=4, out_rdy=0 -> next cycle out_vld=0, out_data=0, count=0, in_rdy=1. No pre-reset data reappears afterwards.
